hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage datapath; pairs with the forwarding unit.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Freezes the pipeline while a multi-cycle data-memory access is outstanding.
- Flushes wrong-path instructions on a taken branch resolved in EX, and keeps a stall performance counter.

Parameters:
- REG_W, 5, register address width.
- MAX_WAIT, 15, maximum memory-wait cycles before abort (1..255).
- CNT_W, 16, width of stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- idRs  in  REG_W  source register A of the instruction in ID.
- idRt  in  REG_W  source register B of the instruction in ID.
- idReadRs  in  1  ID instruction actually reads Rs.
- idReadRt  in  1  ID instruction actually reads Rt.
- exRegDst  in  REG_W  destination register of the instruction in EX.
- exMemRead  in  1  EX instruction is a load.
- exRegWrite  in  1  EX instruction writes the register file.
- branchTaken  in  1  taken branch/jump resolved in EX this cycle.
- memReq  in  1  MEM stage issues a data-memory access this cycle.
- memAck  in  1  data memory completes the access.
- cntClr  in  1  synchronous clear of stallCount.
- pcWrite  out  1  PC register enable.
- ifidWrite  out  1  IF/ID register enable.
- ifidFlush  out  1  load NOP into IF/ID.
- idexFlush  out  1  load NOP into ID/EX.
- pipeHold  out  1  freeze EX/MEM and MEM/WB registers.
- memAbort  out  1  one-cycle pulse on wait timeout.
- memTimeout  out  1  sticky timeout error flag.
- stallCount  out  CNT_W  saturating count of cycles with pcWrite=0.

Behaviour:
- States: RUN, MEM_WAIT. Reset: state=RUN, waitCnt=0, pendFlush=0, memTimeout=0, stallCount=0.
- Control outputs are combinational from state and inputs. During reset: pcWrite=1, ifidWrite=1, all other outputs 0.
- luHaz = exMemRead & exRegWrite & (exRegDst!=0) & ((idReadRs & idRs==exRegDst) | (idReadRt & idRt==exRegDst)).
- Register 0 never causes a hazard.
- Memory wait (highest priority):
  - Enter: in RUN, memReq=1 & memAck=0. That cycle and every MEM_WAIT cycle: pipeHold=1, pcWrite=0, ifidWrite=0, ifidFlush=0, idexFlush=0.
  - Next state is MEM_WAIT; waitCnt is 1 on the first MEM_WAIT cycle.
  - memReq=1 & memAck=1 in RUN is a zero-wait access: no hold.
- In MEM_WAIT:
  - memAck=1: hold is still asserted that cycle. Next state RUN, waitCnt=0.
  - memAck=0 & waitCnt==MAX_WAIT: memAbort=1 and memTimeout=1 (sticky until reset). Hold is asserted that cycle. Next state RUN.
  - Otherwise waitCnt increments.
- Branch flush, in RUN with no memory wait:
  - branchTaken=1 -> ifidFlush=1, idexFlush=1, pcWrite=1, ifidWrite=1.
  - Branch wins over luHaz; the ID instruction is wrong-path, so no stall.
- branchTaken during any hold cycle sets pendFlush. pendFlush is applied as a branch flush on the first RUN cycle with no hold, then cleared.
- Load-use, in RUN with no hold and no flush:
  - luHaz=1 -> pcWrite=0, ifidWrite=0, idexFlush=1 for exactly that cycle.
  - Next cycle the bubble occupies EX, so luHaz drops and forwarding covers the load.
  - During MEM_WAIT, luHaz is ignored.
- Default RUN: pcWrite=1, ifidWrite=1, all other outputs 0.
- stallCount:
  - Increments each cycle pcWrite=0 and saturates at all-ones.
  - cntClr has priority over increment: the register becomes 0 next edge.
- Reset mid-wait returns immediately to RUN with all counters and flags cleared.
- A memAck without an outstanding wait is ignored.

Test Plan:
- exMemRead=1, exRegWrite=1, exRegDst=8, idRs=8, idReadRs=1 -> one cycle pcWrite=0, ifidWrite=0, idexFlush=1; next cycle with exMemRead=0, normal run; stallCount=1.
- Same as above but exRegDst=0, or idReadRs=0 -> no stall; also idRt=8 with idReadRt=1 -> stall.
- memReq=1, memAck low for 3 cycles then high -> pipeHold=1 for 4 cycles; returns to RUN; stallCount=4. Same-cycle ack -> no hold.
- MAX_WAIT=15, memReq=1, memAck never -> memAbort pulses on the 16th hold cycle; memTimeout stays 1; state RUN; only rst_n clears it.
- branchTaken=1 while luHaz=1 -> ifidFlush=1, idexFlush=1, pcWrite=1, no stall. branchTaken during MEM_WAIT -> flush on first cycle after ack.
- Force stallCount to all-ones, keep stalling -> value holds. Assert cntClr together with a stall -> value 0 next cycle. Assert rst_n low mid-MEM_WAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: load-use bubble, memory-wait freeze, branch flush and
// saturating stall counter for the 5-stage pipeline.
module hazard_controller #(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idReadRs,
  input  logic             idReadRt,
  input  logic [REG_W-1:0] exRegDst,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memAck,
  input  logic             cntClr,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             pipeHold,
  output logic             memAbort,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCount
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             pend_q, pend_d, tout_q, tout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_haz, hold, flush, stall;
  always_comb begin
    lu_haz = exMemRead & exRegWrite & (exRegDst != '0) &
             ((idReadRs & (idRs == exRegDst)) | (idReadRt & (idRt == exRegDst)));
    // gating with rst_n keeps outputs at their idle values while reset is held
    hold = rst_n & ((state_q == MEM_WAIT) | (memReq & ~memAck));
    flush = rst_n & ~hold & (branchTaken | pend_q);
    stall = rst_n & ~hold & ~flush & lu_haz;
    memAbort = rst_n & (state_q == MEM_WAIT) & ~memAck & (wait_q == 8'(MAX_WAIT));
    pcWrite = ~(hold | stall);
    ifidWrite = ~(hold | stall);
    ifidFlush = flush;
    idexFlush = flush | stall;
    pipeHold = hold;
    memTimeout = tout_q | memAbort;
    stallCount = cnt_q;
    state_d = (state_q == RUN) ? (hold ? MEM_WAIT : RUN) : ((memAck | memAbort) ? RUN : MEM_WAIT);
    wait_d = (state_d == MEM_WAIT) ? wait_q + 8'd1 : 8'd0;
    pend_d = (hold & branchTaken) | (pend_q & ~flush);
    tout_d = tout_q | memAbort;
    cnt_d = cntClr ? '0 : (~pcWrite & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scenario tasks plus randomized run against a cycle-level reference model.
module tb_hazard_controller;
  localparam int REG_W = 5, MAX_WAIT = 15, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [REG_W-1:0] idRs = '0, idRt = '0, exRegDst = '0;
  logic idReadRs = 0, idReadRt = 0, exMemRead = 0, exRegWrite = 0;
  logic branchTaken = 0, memReq = 0, memAck = 0, cntClr = 0;
  logic pcWrite, ifidWrite, ifidFlush, idexFlush, pipeHold, memAbort, memTimeout;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W+6:0] obs;
  int n_tests = 0, n_fail = 0;
  bit m_wait, m_pend, m_to;
  int m_wcnt, m_cnt;
  bit e_hold, e_abort, e_fl, e_st, e_pc;
  logic [CNT_W+6:0] e_vec;
  localparam logic [CNT_W+6:0] RST_VEC = {2'b11, 5'b0, {CNT_W{1'b0}}};

  hazard_controller #(.REG_W(REG_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .idRs(idRs), .idRt(idRt), .idReadRs(idReadRs),
    .idReadRt(idReadRt), .exRegDst(exRegDst), .exMemRead(exMemRead),
    .exRegWrite(exRegWrite), .branchTaken(branchTaken), .memReq(memReq),
    .memAck(memAck), .cntClr(cntClr), .pcWrite(pcWrite), .ifidWrite(ifidWrite),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .pipeHold(pipeHold),
    .memAbort(memAbort), .memTimeout(memTimeout), .stallCount(stallCount));

  assign obs = {pcWrite, ifidWrite, ifidFlush, idexFlush, pipeHold, memAbort, memTimeout, stallCount};
  always #5 clk = ~clk;

  task automatic model_clear();
    m_wait = 0; m_pend = 0; m_to = 0; m_wcnt = 0; m_cnt = 0;
  endtask

  task automatic model_eval();
    bit haz;
    haz = exMemRead && exRegWrite && exRegDst != 0 &&
          ((idReadRs && idRs == exRegDst) || (idReadRt && idRt == exRegDst));
    e_hold = m_wait || (memReq && !memAck);
    e_abort = m_wait && !memAck && m_wcnt == MAX_WAIT;
    e_fl = !e_hold && (branchTaken || m_pend);
    e_st = !e_hold && !e_fl && haz;
    e_pc = !(e_hold || e_st);
    e_vec = {e_pc, e_pc, e_fl, e_fl || e_st, e_hold, e_abort, m_to || e_abort, CNT_W'(m_cnt)};
  endtask

  task automatic tick();
    model_eval();
    if (cntClr) m_cnt = 0; else if (!e_pc && m_cnt < CMAX) m_cnt++;
    m_to = m_to || e_abort;
    if (e_hold && branchTaken) m_pend = 1; else if (e_fl) m_pend = 0;
    if (!m_wait) begin
      if (e_hold) begin m_wait = 1; m_wcnt = 1; end
    end else if (memAck || e_abort) begin m_wait = 0; m_wcnt = 0; end
    else m_wcnt++;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    idRs = 0; idRt = 0; exRegDst = 0; idReadRs = 0; idReadRt = 0; exMemRead = 0;
    exRegWrite = 0; branchTaken = 0; memReq = 0; memAck = 0; cntClr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_inputs(); model_clear();
    @(negedge clk);
    n_tests++;
    if (obs !== RST_VEC) begin n_fail++; $display("FAIL reset obs=%h exp=%h", obs, RST_VEC); end
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_load_use();
    logic [REG_W+REG_W+REG_W+3:0] tbl [4];
    tbl[0] = {5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = {5'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = {5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = {5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1};
    exMemRead = 1; exRegWrite = 1; exRegDst = 8; idRs = 8; idReadRs = 1;
    @(negedge clk);
    n_tests++;
    if ({pcWrite, ifidWrite, idexFlush, ifidFlush} !== 4'b0010) begin
      n_fail++; $display("FAIL lu_stall obs=%b exp=0010", {pcWrite, ifidWrite, idexFlush, ifidFlush});
    end
    tick();
    exMemRead = 0;
    @(negedge clk);
    n_tests++;
    if ({pcWrite, idexFlush, stallCount} !== {2'b10, 4'd1}) begin
      n_fail++; $display("FAIL lu_after obs=%b exp=%b", {pcWrite, idexFlush, stallCount}, {2'b10, 4'd1});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      {exRegDst, idRs, idRt, idReadRs, idReadRt} = tbl[i][REG_W*3+3:2];
      exMemRead = 1; exRegWrite = 1;
      @(negedge clk); model_eval();
      n_tests++;
      if (pcWrite !== !tbl[i][0] || obs !== e_vec) begin
        n_fail++; $display("FAIL lu_case%0d obs=%h exp=%h", i, obs, e_vec);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    cntClr = 1; tick(); cntClr = 0;
    memReq = 1;
    for (int i = 0; i < 4; i++) begin
      memAck = (i == 3);
      @(negedge clk); model_eval();
      n_tests++;
      if (pipeHold !== 1'b1 || pcWrite !== 1'b0 || obs !== e_vec) begin
        n_fail++; $display("FAIL mem_hold%0d obs=%h exp=%h", i, obs, e_vec);
      end
      tick();
    end
    memReq = 0; memAck = 0;
    @(negedge clk);
    n_tests++;
    if ({pipeHold, pcWrite, stallCount} !== {2'b01, 4'd4}) begin
      n_fail++; $display("FAIL mem_done obs=%b exp=%b", {pipeHold, pcWrite, stallCount}, {2'b01, 4'd4});
    end
    tick();
    memReq = 1; memAck = 1;
    @(negedge clk);
    n_tests++;
    if ({pipeHold, pcWrite} !== 2'b01) begin
      n_fail++; $display("FAIL zero_wait obs=%b exp=01", {pipeHold, pcWrite});
    end
    tick(); clear_inputs();
  endtask

  task automatic test_timeout();
    memReq = 1; memAck = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_tests++;
      if ({pipeHold, memAbort} !== {1'b1, i == 16} || (i == 16 && memTimeout !== 1'b1)) begin
        n_fail++; $display("FAIL timeout_cyc%0d hold_abort_to=%b%b%b exp_abort=%0d", i, pipeHold, memAbort, memTimeout, i == 16);
      end
      tick();
    end
    memReq = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({pipeHold, memAbort, memTimeout} !== 3'b001) begin
        n_fail++; $display("FAIL timeout_sticky%0d obs=%b exp=001", i, {pipeHold, memAbort, memTimeout});
      end
      tick();
    end
  endtask

  task automatic test_branch();
    exMemRead = 1; exRegWrite = 1; exRegDst = 8; idRs = 8; idReadRs = 1; branchTaken = 1;
    @(negedge clk);
    n_tests++;
    if ({ifidFlush, idexFlush, pcWrite, ifidWrite} !== 4'b1111) begin
      n_fail++; $display("FAIL branch_over_lu obs=%b exp=1111", {ifidFlush, idexFlush, pcWrite, ifidWrite});
    end
    tick(); clear_inputs();
    memReq = 1;
    for (int i = 0; i < 5; i++) begin
      branchTaken = (i == 1); memAck = (i == 2); memReq = (i < 3);
      @(negedge clk); model_eval();
      n_tests++;
      if (ifidFlush !== (i == 3) || obs !== e_vec) begin
        n_fail++; $display("FAIL pend_flush%0d obs=%h exp=%h", i, obs, e_vec);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_counter_sat();
    cntClr = 1; tick(); cntClr = 0;
    exMemRead = 1; exRegWrite = 1; exRegDst = 3; idRt = 3; idReadRt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if (stallCount !== CNT_W'(i > CMAX ? CMAX : i)) begin
        n_fail++; $display("FAIL sat%0d obs=%0d exp=%0d", i, stallCount, i > CMAX ? CMAX : i);
      end
      tick();
    end
    cntClr = 1; tick(); cntClr = 0;
    @(negedge clk);
    n_tests++;
    if (stallCount !== '0) begin n_fail++; $display("FAIL clr_prio obs=%0d exp=0", stallCount); end
    tick(); clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    memReq = 1; memAck = 0; branchTaken = 1;
    tick(); tick();
    #2 rst_n = 0; #1;
    n_tests++;
    if (obs !== RST_VEC) begin n_fail++; $display("FAIL async_reset obs=%h exp=%h", obs, RST_VEC); end
    clear_inputs(); model_clear();
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      idRs = REG_W'($urandom_range(0, 3)); idRt = REG_W'($urandom_range(0, 3));
      exRegDst = REG_W'($urandom_range(0, 3));
      {idReadRs, idReadRt, exMemRead, exRegWrite} = 4'($urandom);
      memReq = ($urandom_range(0, 3) == 0); memAck = 1'($urandom);
      branchTaken = ($urandom_range(0, 7) == 0); cntClr = ($urandom_range(0, 31) == 0);
      @(negedge clk); model_eval();
      n_tests++;
      if (obs !== e_vec) begin n_fail++; $display("FAIL random%0d obs=%h exp=%h", i, obs, e_vec); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_reset();
    test_branch();
    test_counter_sat();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
